// File: rtl/cv_sp_pkg.sv
// Shared definitions for the sprite line pipeline: controller state encoding,
// the default line-buffer clear depth, and the widths of the line counter and
// the sprite search count. Shared with the search and render units.
package cv_sp_pkg;

    localparam int CV_SP_CLR_DEPTH = 256;
    localparam int CV_SP_VCNT_W    = 10;
    localparam int CV_SP_SCNT_W    = 11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_RENDER = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ABORT  = 3'd5;

endpackage

// File: rtl/cv_sp_line_ctrl_if.sv
// Handshake bundle between the line controller (master) and the sprite
// search/render units (slave).
interface cv_sp_line_ctrl_if;
    import cv_sp_pkg::*;

    logic                    search_cs;
    logic                    search_end;
    logic [CV_SP_SCNT_W-1:0] search_count_in;
    logic [CV_SP_SCNT_W-1:0] search_count;
    logic                    render_cs;
    logic [CV_SP_VCNT_W-1:0] render_v_count;
    logic                    render_end;

    modport master (
        output search_cs, search_count, render_cs, render_v_count,
        input  search_end, search_count_in, render_end
    );

    modport slave (
        input  search_cs, search_count, render_cs, render_v_count,
        output search_end, search_count_in, render_end
    );

endinterface

// File: rtl/cv_sp_sat_cnt.sv
// 8-bit saturating event counter: counts i_inc pulses and sticks at 255.
module cv_sp_sat_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    // Count up on each event until all ones, then hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != 8'hFF))
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cv_sp_line_ctrl.sv
// Sprite scanline controller: on each accepted line_start it flips the
// line-buffer bank, optionally clears the bank being built, then sequences
// the search and render units. A line_start that arrives mid-line aborts the
// line for one cycle, is counted as an overrun, and then restarts the line.
// Optional feature macro: CV_SP_LINE_CLEAR_EN (enables the CLEAR phase).
module cv_sp_line_ctrl
    import cv_sp_pkg::*;
#(
    parameter int CLR_DEPTH = CV_SP_CLR_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    line_start,
    input  logic [CV_SP_VCNT_W-1:0] v_count,
    cv_sp_line_ctrl_if.master       bus,
    output logic                    build_bank,
    output logic [CV_SP_VCNT_W-1:0] clr_addr,
    output logic                    clr_wen,
    output logic                    busy,
    output logic                    overrun,
    output logic [7:0]              overrun_cnt
);

    localparam logic [CV_SP_VCNT_W-1:0] LAST_ADDR = CV_SP_VCNT_W'(CLR_DEPTH - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    r_en;
    logic                    r_pend_en;
    logic [CV_SP_VCNT_W-1:0] r_pend_vcnt;
    logic                    r_bank;
    logic [CV_SP_VCNT_W-1:0] r_rvcnt;
    logic [CV_SP_SCNT_W-1:0] r_scnt;
    logic                    r_search_cs;
    logic                    r_render_cs;
    logic                    r_busy;
    logic                    r_overrun;
    logic [CV_SP_VCNT_W-1:0] r_clr_addr;
    logic                    w_ovr;
    logic                    w_accept;
    logic                    w_acc_en;
    logic [CV_SP_VCNT_W-1:0] w_acc_vcnt;
    logic [2:0]              w_start_state;
    logic                    w_clr_last;

    // Next-state decode; an overrun always wins over search_end/render_end
    always_comb begin
        w_ovr      = line_start && ((r_state == ST_CLEAR) || (r_state == ST_SEARCH) ||
                                    (r_state == ST_RENDER));
        w_accept   = (line_start && ((r_state == ST_IDLE) || (r_state == ST_DONE))) ||
                     (r_state == ST_ABORT);
        w_acc_en   = (r_state == ST_ABORT) ? r_pend_en   : enable;
        w_acc_vcnt = (r_state == ST_ABORT) ? r_pend_vcnt : v_count;
`ifdef CV_SP_LINE_CLEAR_EN
        w_start_state = ST_CLEAR;
`else
        w_start_state = w_acc_en ? ST_SEARCH : ST_DONE;
`endif
        w_clr_last  = (r_clr_addr == LAST_ADDR);
        w_state_nxt = r_state;
        if (w_ovr) begin
            w_state_nxt = ST_ABORT;
        end else if (w_accept) begin
            w_state_nxt = w_start_state;
        end else begin
            case (r_state)
                ST_CLEAR:  if (w_clr_last) w_state_nxt = r_en ? ST_SEARCH : ST_DONE;
                ST_SEARCH: if (bus.search_end) w_state_nxt = ST_RENDER;
                ST_RENDER: if (bus.render_end) w_state_nxt = ST_DONE;
                ST_IDLE, ST_DONE: w_state_nxt = r_state;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State plus registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_pend_en   <= 1'b0;
            r_pend_vcnt <= '0;
            r_bank      <= 1'b0;
            r_rvcnt     <= '0;
            r_scnt      <= '0;
            r_search_cs <= 1'b0;
            r_render_cs <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_clr_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_en    <= w_acc_en;
                r_bank  <= ~r_bank;
                r_rvcnt <= w_acc_vcnt + CV_SP_VCNT_W'(1);
            end
            if (w_ovr) begin
                r_pend_en   <= enable;
                r_pend_vcnt <= v_count;
            end
            if ((r_state == ST_SEARCH) && (w_state_nxt == ST_RENDER))
                r_scnt <= bus.search_count_in;
            r_search_cs <= (w_state_nxt == ST_SEARCH);
            r_render_cs <= (w_state_nxt == ST_RENDER);
            r_busy      <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_SEARCH) ||
                           (w_state_nxt == ST_RENDER) || (w_state_nxt == ST_ABORT);
            r_overrun   <= w_ovr;
            r_clr_addr  <= ((r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR)) ?
                           r_clr_addr + CV_SP_VCNT_W'(1) : '0;
        end
    end

`ifdef CV_SP_LINE_CLEAR_EN
    logic r_clr_wen;

    // Clear strobe is high for every cycle spent in CLEAR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_clr_wen <= 1'b0;
        else
            r_clr_wen <= (w_state_nxt == ST_CLEAR);
    end

    assign clr_wen  = r_clr_wen;
    assign clr_addr = r_clr_addr;
`else
    assign clr_wen  = 1'b0;
    assign clr_addr = '0;
`endif

    cv_sp_sat_cnt u_ovr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_ovr),
        .o_cnt   (overrun_cnt)
    );

    assign bus.search_cs      = r_search_cs;
    assign bus.search_count   = r_scnt;
    assign bus.render_cs      = r_render_cs;
    assign bus.render_v_count = r_rvcnt;
    assign build_bank         = r_bank;
    assign busy               = r_busy;
    assign overrun            = r_overrun;

endmodule

// File: doc/cv_sp_line_ctrl.md
CV_SP_LINE_CTRL -- requirements
Module: cv_sp_line_ctrl

Interface
REQ-001 SHALL have parameter CLR_DEPTH, default 256, the number of line-buffer words cleared per line (2..1024).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide these ports, one per line:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  sprite enable; sampled only on an accepted line_start.
- line_start  in  1  one-cycle pulse at the start of each scanline.
- v_count  in  10  current display line.
- search_cs  out  1  select for the sprite search unit.
- search_end  in  1  search-done pulse from the search unit.
- search_count_in  in  11  number of sprites found by the search unit.
- search_count  out  11  latched search count, fed to the render unit.
- render_cs  out  1  select for the render unit.
- render_v_count  out  10  line being built.
- render_end  in  1  render-done from the render unit.
- build_bank  out  1  line-buffer half being built; the display reads the other half.
- clr_addr  out  10  clear write address.
- clr_wen  out  1  clear strobe; writes zero to all four lanes at clr_addr.
- busy  out  1  high in CLEAR, SEARCH, RENDER and ABORT.
- overrun  out  1  one-cycle pulse when line_start arrives while busy.
- overrun_cnt  out  8  saturating overrun count.

Function
REQ-004 SHALL implement the states IDLE, CLEAR, SEARCH, RENDER, DONE and ABORT.
REQ-005 line_start in IDLE or DONE SHALL be accepted:
- build_bank toggles on that edge.
- render_v_count loads v_count+1, wrapping modulo 1024.
- enable is latched.
- Next state is CLEAR.
REQ-006 CLEAR SHALL last exactly CLR_DEPTH cycles:
- clr_wen=1 throughout.
- clr_addr runs 0..CLR_DEPTH-1, one step per cycle.
- Exit goes to SEARCH if the latched enable=1, else to DONE.
REQ-007 search_cs SHALL be 1 exactly while in SEARCH.
- search_end=1 in SEARCH latches search_count_in into search_count.
- The same edge moves the state to RENDER.
REQ-008 render_cs SHALL be 1 exactly while in RENDER; render_end=1 in RENDER SHALL move the state to DONE.
REQ-009 In DONE, search_cs and render_cs SHALL be 0, which resets the downstream unit FSMs; DONE holds until line_start.
REQ-010 line_start in CLEAR, SEARCH or RENDER SHALL:
- Pulse overrun the next cycle.
- Increment overrun_cnt, saturating at 255.
- Go to ABORT for one cycle, with both cs low and clr_wen=0.
- Then behave exactly as an accepted line_start (REQ-005).
REQ-011 line_start in ABORT SHALL be ignored.
REQ-012 A search_end or render_end that arrives outside its own state SHALL be ignored.
REQ-013 search_end and line_start in the same cycle SHALL be resolved in favour of line_start (the overrun path).
REQ-014 Latency: line_start at cycle 0 SHALL give CLEAR from cycle 1 to CLR_DEPTH and search_cs high from cycle CLR_DEPTH+1.
REQ-015 All outputs SHALL be registered; clr_addr bits above log2(CLR_DEPTH) SHALL be 0.

Reset
REQ-016 On reset_n=0 the block SHALL enter IDLE, independent of clk.
REQ-017 All outputs SHALL be 0 during reset, including build_bank, search_count, render_v_count and overrun_cnt.
REQ-018 Reset asserted mid-line SHALL abandon the line immediately, with no further clr_wen or cs.
REQ-019 The first line_start after reset SHALL set build_bank to 1.

Configuration
REQ-020 With macro CV_SP_LINE_CLEAR_EN defined, CLEAR SHALL exist as specified.
REQ-021 With CV_SP_LINE_CLEAR_EN undefined:
- CLEAR is removed; the render unit clears the buffer on display read.
- An accepted line_start goes straight to SEARCH, or to DONE if disabled.
- clr_wen and clr_addr are tied to 0.
- search_cs rises at cycle 1 after line_start.

Structure
REQ-022 cv_sp_pkg SHALL hold the state encoding, the CLR_DEPTH default, the v_count width (10) and the search-count width (11), shared with the search and render units.
REQ-023 One sub-module is natural: cv_sp_sat_cnt, an 8-bit saturating increment counter for overrun_cnt; everything else is inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Nominal: enable=1, v_count=100, line_start at t0 -> clr_wen high t1..t256, clr_addr 0..255, search_cs from t257; search_end with count 5 -> search_count=5, render_cs next cycle; render_end -> DONE, busy=0, render_v_count=101, build_bank=1.
- Wrap: v_count=1023 -> render_v_count=0.
- Disabled: enable=0 -> CLEAR runs 256 cycles, then DONE; search_cs never rises; build_bank still toggles.
- Overrun: line_start during RENDER -> overrun pulse, overrun_cnt=1, both cs low for 1 cycle, build_bank toggles, CLEAR restarts at addr 0; 300 overruns -> overrun_cnt=255.
- Simultaneous: search_end and line_start in the same SEARCH cycle -> overrun path taken, search_count unchanged.
- Reset: reset_n low at clr_addr=40 -> all outputs 0 asynchronously; the next line_start sets build_bank=1 (REQ-019); without CV_SP_LINE_CLEAR_EN, search_cs rises at t1.
